// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs WIDTH-bit ALU operations on a shared 4-bit
// combinational slice, one nibble per clock, LSB nibble first, chaining the
// slice's active-low carry from nibble to nibble.
module alu_nibble_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             m_in,
    input  logic [3:0]       s_in,
    input  logic             cin_n_in,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_m,
    output logic [3:0]       alu_s,
    output logic             alu_cin,
    input  logic [3:0]       alu_f,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] result,
    output logic             cout_n,
    output logic             done,
    output logic             busy
);

    // WIDTH is expected to be a non-zero multiple of 4.
    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned OFF_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               m_q;
    logic [3:0]         s_q;
    logic               carry_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   result_q;
    logic               cout_n_q;
    logic [OFF_W-1:0]   nib_off;
    logic               run;

    assign run     = (state_q == S_RUN);
    assign nib_off = {idx_q, 2'b00};

    // Accumulator with the current nibble replaced by the slice result.
    always_comb begin
        acc_d              = acc_q;
        acc_d[nib_off +: 4] = alu_f;
    end

    // Sequencer state, operand latches, carry chain and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= 1'b0;
            s_q      <= 4'h0;
            carry_q  <= 1'b1;
            acc_q    <= '0;
            result_q <= '0;
            cout_n_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        m_q     <= m_in;
                        s_q     <= s_in;
                        carry_q <= cin_n_in;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= alu_cout;
                    if (idx_q == IDX_LAST) begin
                        result_q <= acc_d;
                        cout_n_q <= alu_cout;
                        idx_q    <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake status decoded from the state register.
    assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy  = run;
    assign done  = (state_q == S_DONE);

    // Slice drive comes from registers only; parked values outside RUN.
    assign alu_a   = run ? a_q[nib_off +: 4] : 4'h0;
    assign alu_b   = run ? b_q[nib_off +: 4] : 4'h0;
    assign alu_s   = run ? s_q : 4'h0;
    assign alu_m   = run & m_q;
    assign alu_cin = run ? carry_q : 1'b1;

    assign result = result_q;
    assign cout_n = cout_n_q;

endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Multi-cycle controller that runs WIDTH-bit ALU operations on the existing 4-bit combinational ALU slice, one nibble per clock, least-significant nibble first. It latches a full-width request, drives the slice's A/B/M/S/carry inputs nibble by nibble, and chains the slice's carry-out into the next nibble's carry-in. It collects the nibble results into a full-width result and reports completion. It sits between the datapath control (requester) and a single shared 4-bit ALU instance.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of 4, minimum 4.
- NIB, WIDTH/4: number of nibble passes (derived, not overridable).

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only when ready=1.
- ready  out  1  high in IDLE and DONE.
- a_in, b_in  in  WIDTH  operands.
- m_in  in  1  mode: 1 = logic, 0 = arithmetic (passed through to slice).
- s_in  in  4  function select (passed through to slice).
- cin_n_in  in  1  active-low carry-in for nibble 0 (slice convention: 1 = no carry).
- alu_a, alu_b  out  4  current nibble of latched operands.
- alu_m  out  1  latched mode.
- alu_s  out  4  latched select.
- alu_cin  out  1  active-low carry to slice.
- alu_f  in  4  slice result (combinational from alu_* outputs).
- alu_cout  in  1  slice active-low carry-out.
- result  out  WIDTH  completed result; held until the next completion.
- cout_n  out  1  final active-low carry-out of the top nibble.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch a_in, b_in, m_in, s_in into op registers, set carry register to cin_n_in and idx to 0, then go to RUN. start=0 keeps the block in IDLE.
- RUN, cycle with index idx:
  - alu_a = A_reg[4*idx+3:4*idx], alu_b likewise, alu_cin = carry register.
  - On the clock edge: acc[4*idx+3:4*idx] <= alu_f, carry <= alu_cout, idx <= idx+1.
  - When idx==NIB-1: copy the final acc (including this nibble) into result, set cout_n <= alu_cout, and go to DONE.
- Carry chaining is direct, with no inversion: the slice's carry-in and carry-out share the same active-low sense.
- Logic mode (m=1) uses the identical sequence. Carry is still chained and cout_n reports the top slice's carry-out; consumers ignore it.
- DONE: done=1 for exactly this cycle, then go to IDLE. A start in DONE is accepted exactly as in IDLE, so the next state is RUN.
- start while busy=1 is ignored. The op registers must not change during RUN.
- Outside RUN, alu_a, alu_b and alu_s are 0, alu_m is 0, and alu_cin is 1.
- Reset (any state, including mid-RUN): state IDLE, idx=0, acc=0, result=0, cout_n=1, done=0, busy=0, ready=1, op registers=0, carry register=1. Any in-flight operation is abandoned with no done pulse.

## Timing
- The start-accept edge is edge 0.
- Nibble k is driven during the cycle after edge k and captured on edge k+1, for k = 0..NIB-1.
- result, cout_n and done become valid after edge NIB. done is high for the one cycle following edge NIB.
- Latency: start to done is NIB+1 cycles (5 for WIDTH=16).
- Throughput: one operation per NIB+1 cycles with back-to-back start.
- result changes only on the edge entering DONE (and on reset).
- The slice path is purely combinational within one cycle: the alu_* outputs are driven from registers only, with no dependence on start in the same cycle.

## Test plan
- Add: m=0, s=9, a=0x1234, b=0x0FCD, cin_n=1 -> result 0x2201, cout_n=1, done pulses 5 cycles after start; alu_a sequence 4,3,2,1.
- Overflow/carry ripple: s=9, a=0xFFFF, b=0x0001, cin_n=1 -> result 0x0000, cout_n=0; alu_cin per nibble 1,0,0,0.
- Subtract: s=6 (A+~B+carry), a=0x0005, b=0x0003, cin_n=0 -> result 0x0002, cout_n=0. The same operands with cin_n=1 -> result 0x0001.
- Logic XOR: m=1, s=6, a=0xF0F0, b=0x0FF0 -> result 0xFF00, done after 5 cycles. All-ones: m=0, s=3, cin_n=1 -> 0xFFFF.
- Handshake: assert start continuously for 12 cycles with changing operands. Only the operands at the IDLE edge and at each DONE edge are taken, and done pulses every 5 cycles. Operand changes during RUN do not alter alu_a, alu_b, alu_s or result.
- Reset mid-op: start an add and assert rst after edge 2 -> next cycle busy=0, ready=1, result=0, cout_n=1, no done pulse. A following start completes normally.
